gate_test_sequencer: RTL and testbench
======================================

# gate_test_sequencer

Self-checking stimulus controller for the delay-annotated gate models `not_delay`, `nand_delay` and `flip_flop_delay`. It sequences a fixed set of eight test vectors into the three devices under test, one vector at a time. For each vector it counts clock edges until the DUT output matches the expected value, or until a timeout. At the end it reports pass/fail, a per-vector failure mask and the worst observed latency. It replaces hand-written stimulus in the gate benches and drives `clk` as the flop's clock.

## Interface
- `TIMEOUT`, 15: maximum WAIT edges per vector; legal range 1 to 2^`LAT_W`−1.
- `LAT_W`, 4: width of the latency counter and of `max_lat`.

- `clk` input 1: single clock; also the DUT flop clock. All state updates on its rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `start` input 1: run request; sampled only in IDLE.
- `out_not`, `out_nand`, `q_flop` input 1 each: DUT outputs.
- `in_not`, `in1_nand`, `in2_nand`, `d_flop` output 1 each: registered DUT stimulus.
- `busy` output 1: run in progress (APPLY or WAIT).
- `done` output 1: one-cycle pulse at end of run.
- `pass` output 1: last run had zero failures; held until the next accepted `start`.
- `err_count` output 4: number of failed vectors in the last run.
- `fail_mask` output 8: bit k set means vector k timed out.
- `max_lat` output `LAT_W`: largest passing latency in the last run.

## Operation
- Vector table (index: stimulus -> checked output == expected):
  - 0: `in_not`=0 -> `out_not`==1
  - 1: `in_not`=1 -> `out_not`==0
  - 2–5: (`in1_nand`,`in2_nand`) = 00, 01, 10, 11 -> `out_nand`==~(a&b)
  - 6: `d_flop`=1 -> `q_flop`==1
  - 7: `d_flop`=0 -> `q_flop`==0
- Stimulus for DUTs not under test holds its last value.
- FSM states: IDLE, APPLY, WAIT, DONE.
  - IDLE: when `start`=1, clear `err_count`, `fail_mask`, `max_lat` and `pass`; set idx=0; go to APPLY. Otherwise stay in IDLE.
  - APPLY: load the stimulus registers from the table entry at idx; set lat=1; go to WAIT.
  - WAIT, match (checked output == expected): set `max_lat` = max(`max_lat`, lat) and resolve the vector.
  - WAIT, no match and lat==`TIMEOUT`: set `fail_mask`[idx]; increment `err_count`; resolve the vector.
  - WAIT, otherwise: increment lat and stay in WAIT.
  - A match on the same edge as lat==`TIMEOUT` counts as a pass.
  - Resolve: if idx==7 go to DONE; else increment idx and go to APPLY.
  - DONE: assert `done` for one cycle; `pass` = (`err_count`==0), computed including the last vector; go to IDLE.
- `start` is ignored in APPLY, WAIT and DONE; no queuing.
- `lat` never exceeds `TIMEOUT`, so no wrap-around is possible. `err_count` maximum is 8.
- Reset (any state, any time, asynchronous): state=IDLE, idx=0, all outputs 0, all stimulus outputs 0.

## Timing
- The edge that samples `start` (E0) moves to APPLY, and `busy` goes high after E0.
- Each vector takes 1 APPLY edge + lat WAIT edges.
- DUT outputs are sampled at the rising edge.
  - Combinational gate delay below one period gives lat=1.
  - Flop vectors need lat≥2: D is captured at the first WAIT edge, and Q is visible at the second.
- Total run length is 8 + Σlat edges after E0 until DONE is entered.
  - `done` is high for exactly the one cycle in DONE.
  - `busy` is low in DONE.
- `pass`, `err_count`, `fail_mask`, `max_lat` are stable from DONE until the next accepted `start`.
- Outputs are purely registered; no combinational path from `out_*`/`q_flop` to any output.

## Test plan
- Reset: assert `reset_L`=0 with `clk` running -> all outputs 0, `busy`=0. Release, no `start` -> outputs stay 0.
- Nominal run: gate delays 1, clk-to-q 1, period 10, pulse `start` -> `done` pulses with DONE entered 18 edges after E0 (6×2 + 2×3). `pass`=1, `err_count`=0, `fail_mask`=8'h00, `max_lat`=2.
- Stuck NAND: force `out_nand`=1 -> vector 5 times out after 15 WAIT edges. DONE entered 32 edges after E0; `fail_mask`=8'h20, `err_count`=1, `pass`=0.
- Boundary latency: `TIMEOUT`=3, `not_delay` delay 25, period 10 -> match on the 3rd WAIT edge for vectors 0–1, treated as pass. `max_lat`=3, `pass`=1.
- `start` held high through the whole run -> exactly one run. After `done`, a new run begins on the following IDLE edge with results cleared.
- `reset_L` pulsed low during WAIT of vector 3 -> immediately `busy`=0 and stimulus 0. A subsequent `start` yields a clean nominal result identical to the nominal-run scenario.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: walks eight fixed vectors through the NOT, NAND and
// flop gate models. It times each response in clock edges and collects
// run-level pass/fail, a per-vector failure mask and the worst latency.
module gate_test_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int LAT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             out_not,
    input  logic             out_nand,
    input  logic             q_flop,
    output logic             in_not,
    output logic             in1_nand,
    output logic             in2_nand,
    output logic             d_flop,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [7:0]       fail_mask,
    output logic [LAT_W-1:0] max_lat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_DONE
    } state_t;

    // Bit k is the value the checked gate output must reach for vector k:
    // NOT 0->1, 1->0; NAND 00/01/10 -> 1, 11 -> 0; flop D=1 -> 1, D=0 -> 0.
    localparam logic [7:0]       EXPECTED  = 8'b0101_1101;
    localparam logic [2:0]       LAST_IDX  = 3'd7;
    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [2:0]       r_idx;
    logic [LAT_W-1:0] r_lat;
    logic             r_inNot;
    logic             r_in1Nand;
    logic             r_in2Nand;
    logic             r_dFlop;
    logic             r_pass;
    logic [3:0]       r_errCount;
    logic [7:0]       r_failMask;
    logic [LAT_W-1:0] r_maxLat;

    logic             w_observed;
    logic             w_match;
    logic             w_timeout;
    logic             w_resolve;
    logic             w_lastVec;

    // Select which gate output is under test for the current vector.
    always_comb begin
        w_observed = q_flop;
        if (r_idx <= 3'd1) begin
            w_observed = out_not;
        end else if (r_idx <= 3'd5) begin
            w_observed = out_nand;
        end
    end

    // A match wins over the timeout when both happen on the same edge.
    assign w_match   = (w_observed == EXPECTED[r_idx]);
    assign w_timeout = (r_lat == LAT_LIMIT);
    assign w_resolve = (r_state == S_WAIT) && (w_match || w_timeout);
    assign w_lastVec = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one APPLY edge, then WAIT until the vector resolves.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_APPLY;
                end
            end
            S_APPLY: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (w_resolve) begin
                    w_nextState = w_lastVec ? S_DONE : S_APPLY;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_APPLY: busy = 1'b1;
            S_WAIT:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Stimulus registers; only the gate addressed by the vector changes.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_inNot   <= 1'b0;
            r_in1Nand <= 1'b0;
            r_in2Nand <= 1'b0;
            r_dFlop   <= 1'b0;
        end else if (r_state == S_APPLY) begin
            case (r_idx)
                3'd0:    r_inNot <= 1'b0;
                3'd1:    r_inNot <= 1'b1;
                3'd2:    {r_in1Nand, r_in2Nand} <= 2'b00;
                3'd3:    {r_in1Nand, r_in2Nand} <= 2'b01;
                3'd4:    {r_in1Nand, r_in2Nand} <= 2'b10;
                3'd5:    {r_in1Nand, r_in2Nand} <= 2'b11;
                3'd6:    r_dFlop <= 1'b1;
                default: r_dFlop <= 1'b0;
            endcase
        end
    end

    // Vector index and per-vector latency counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_idx <= 3'd0;
            r_lat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx <= 3'd0;
                    end
                end
                S_APPLY: begin
                    r_lat <= LAT_ONE;
                end
                S_WAIT: begin
                    if (w_resolve) begin
                        if (!w_lastVec) begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_lat <= r_lat + LAT_ONE;
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Run results; pass is settled on the edge that enters DONE so it is
    // already valid while done is high.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_pass     <= 1'b0;
            r_errCount <= 4'd0;
            r_failMask <= 8'h00;
            r_maxLat   <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_pass     <= 1'b0;
                r_errCount <= 4'd0;
                r_failMask <= 8'h00;
                r_maxLat   <= '0;
            end
        end else if (r_state == S_WAIT) begin
            if (w_match) begin
                if (r_lat > r_maxLat) begin
                    r_maxLat <= r_lat;
                end
                if (w_lastVec) begin
                    r_pass <= (r_errCount == 4'd0);
                end
            end else if (w_timeout) begin
                r_failMask[r_idx] <= 1'b1;
                r_errCount        <= r_errCount + 4'd1;
                if (w_lastVec) begin
                    r_pass <= 1'b0;
                end
            end
        end
    end

    assign in_not    = r_inNot;
    assign in1_nand  = r_in1Nand;
    assign in2_nand  = r_in2Nand;
    assign d_flop    = r_dFlop;
    assign pass      = r_pass;
    assign err_count = r_errCount;
    assign fail_mask = r_failMask;
    assign max_lat   = r_maxLat;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: delay-annotated gate models, a procedural
// reference model of a run, a per-cycle compare process and directed runs
// with hand-computed run lengths and results.
`timescale 1ns/1ps
module tb_gate_test_sequencer;

    localparam int TIMEOUT = 15;
    localparam int LAT_W   = 4;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             start;
    logic             out_not;
    logic             out_nand;
    logic             q_flop;
    logic             in_not;
    logic             in1_nand;
    logic             in2_nand;
    logic             d_flop;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_count;
    logic [7:0]       fail_mask;
    logic [LAT_W-1:0] max_lat;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int   notDelay  = 1;
    bit   stuckNand = 1'b0;
    logic notOut    = 1'b1;
    logic nandOut   = 1'b1;
    logic flopQ     = 1'b0;

    logic             mBusy   = 1'b0;
    logic             mDone   = 1'b0;
    logic             mPass   = 1'b0;
    logic [3:0]       mErr    = 4'd0;
    logic [7:0]       mMask   = 8'h00;
    logic [LAT_W-1:0] mMaxLat = '0;
    logic             mInNot  = 1'b0;
    logic             mIn1    = 1'b0;
    logic             mIn2    = 1'b0;
    logic             mD      = 1'b0;

    gate_test_sequencer #(
        .TIMEOUT(TIMEOUT),
        .LAT_W  (LAT_W)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .start    (start),
        .out_not  (out_not),
        .out_nand (out_nand),
        .q_flop   (q_flop),
        .in_not   (in_not),
        .in1_nand (in1_nand),
        .in2_nand (in2_nand),
        .d_flop   (d_flop),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_mask(fail_mask),
        .max_lat  (max_lat)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // NOT gate with an adjustable propagation delay.
    always @(in_not) notOut <= #(notDelay) ~in_not;

    // NAND gate with 1 ns delay.
    always @(in1_nand or in2_nand) nandOut <= #1 ~(in1_nand & in2_nand);

    // D flop with 1 ns clock-to-q.
    always @(posedge clk) flopQ <= #1 d_flop;

    assign out_not  = notOut;
    assign out_nand = stuckNand ? 1'b1 : nandOut;
    assign q_flop   = flopQ;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitEdge(output bit aborted);
        @(posedge clk or negedge reset_L);
        aborted = (reset_L !== 1'b1);
    endtask

    task automatic modelReset();
        mBusy   = 1'b0;
        mDone   = 1'b0;
        mPass   = 1'b0;
        mErr    = 4'd0;
        mMask   = 8'h00;
        mMaxLat = '0;
        mInNot  = 1'b0;
        mIn1    = 1'b0;
        mIn2    = 1'b0;
        mD      = 1'b0;
    endtask

    // Vector k: 0/1 drive the NOT input, 2..5 count through the NAND inputs,
    // 6/7 drive D with 1 then 0.
    task automatic modelApply(input int k);
        if (k < 2) begin
            mInNot = (k == 1);
        end else if (k < 6) begin
            mIn1 = (((k - 2) >> 1) & 1) != 0;
            mIn2 = ((k - 2) & 1) != 0;
        end else begin
            mD = (k == 6);
        end
    endtask

    // The value the gate under test must settle to, from its logic function.
    function automatic logic modelExpected(input int k);
        if (k < 2) return ~mInNot;
        if (k < 6) return ~(mIn1 & mIn2);
        return mD;
    endfunction

    function automatic logic modelObserved(input int k);
        if (k < 2) return out_not;
        if (k < 6) return out_nand;
        return q_flop;
    endfunction

    task automatic modelRun();
        bit aborted;
        int lat;
        mPass   = 1'b0;
        mErr    = 4'd0;
        mMask   = 8'h00;
        mMaxLat = '0;
        mBusy   = 1'b1;
        mDone   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            waitEdge(aborted);
            if (aborted) begin
                modelReset();
                return;
            end
            modelApply(k);
            lat = 1;
            forever begin
                waitEdge(aborted);
                if (aborted) begin
                    modelReset();
                    return;
                end
                if (modelObserved(k) === modelExpected(k)) begin
                    if (lat > int'(mMaxLat)) mMaxLat = LAT_W'(lat);
                    break;
                end
                if (lat == TIMEOUT) begin
                    mMask[k] = 1'b1;
                    mErr     = mErr + 4'd1;
                    break;
                end
                lat++;
            end
        end
        mBusy = 1'b0;
        mDone = 1'b1;
        mPass = (mErr == 4'd0);
        waitEdge(aborted);
        if (aborted) begin
            modelReset();
            return;
        end
        mDone = 1'b0;
    endtask

    // Reference model: idle until start is seen on an edge, then play a run.
    always begin : refModel
        bit aborted;
        waitEdge(aborted);
        if (aborted) begin
            modelReset();
        end else if (start === 1'b1) begin
            modelRun();
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy",      32'(busy),      32'(mBusy));
            checkOutput("done",      32'(done),      32'(mDone));
            checkOutput("pass",      32'(pass),      32'(mPass));
            checkOutput("err_count", 32'(err_count), 32'(mErr));
            checkOutput("fail_mask", 32'(fail_mask), 32'(mMask));
            checkOutput("max_lat",   32'(max_lat),   32'(mMaxLat));
            checkOutput("in_not",    32'(in_not),    32'(mInNot));
            checkOutput("in1_nand",  32'(in1_nand),  32'(mIn1));
            checkOutput("in2_nand",  32'(in2_nand),  32'(mIn2));
            checkOutput("d_flop",    32'(d_flop),    32'(mD));
        end
    end

    task automatic waitDone(output int edges);
        bit seen;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = (done === 1'b1);
        end
    endtask

    // Request a run; counts edges after the start-sampling edge until DONE.
    task automatic applyStimulus(input bit holdStart, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        waitDone(edges);
    endtask

    task automatic checkRun(input string tag, input int edges, input int expEdges,
                            input logic expPass, input logic [3:0] expErr,
                            input logic [7:0] expMask, input logic [3:0] expMax);
        checkOutput({tag, ".edges"},     32'(edges),     32'(expEdges));
        checkOutput({tag, ".pass"},      32'(pass),      32'(expPass));
        checkOutput({tag, ".err_count"}, 32'(err_count), 32'(expErr));
        checkOutput({tag, ".fail_mask"}, 32'(fail_mask), 32'(expMask));
        checkOutput({tag, ".max_lat"},   32'(max_lat),   32'(expMax));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".status"},
                    32'({busy, done, pass, err_count, fail_mask, max_lat}), 32'd0);
        checkOutput({tag, ".stimulus"},
                    32'({in_not, in1_nand, in2_nand, d_flop}), 32'd0);
    endtask

    // Directed scenarios.
    initial begin : stimulus
        int edges;
        reset_L = 1'b0;
        start   = 1'b0;

        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkIdle("reset");
        #2 reset_L = 1'b1;
        repeat (4) @(negedge clk);
        checkIdle("postReset");

        // 6 vectors at lat 1 and 2 flop vectors at lat 2: 8 + 10 edges.
        applyStimulus(1'b0, edges);
        checkRun("nominal", edges, 18, 1'b1, 4'd0, 8'h00, 4'd2);

        // Vector 5 runs to the 15-edge timeout: 8 + 7 + 15 + 2.
        stuckNand = 1'b1;
        applyStimulus(1'b0, edges);
        checkRun("stuckNand", edges, 32, 1'b0, 4'd1, 8'h20, 4'd2);
        stuckNand = 1'b0;

        // NOT delay 145 ns: response lands just before the 15th WAIT edge.
        notDelay = 145;
        applyStimulus(1'b0, edges);
        checkRun("latAtTimeout", edges, 46, 1'b1, 4'd0, 8'h00, 4'd15);

        // NOT delay 155 ns: response lands just after the 15th WAIT edge.
        notDelay = 155;
        applyStimulus(1'b0, edges);
        checkRun("latPastTimeout", edges, 46, 1'b0, 4'd2, 8'h03, 4'd2);
        notDelay = 1;

        // start held high: one run, then a fresh run on the following IDLE edge.
        applyStimulus(1'b1, edges);
        checkRun("heldStart", edges, 18, 1'b1, 4'd0, 8'h00, 4'd2);
        @(negedge clk);
        checkOutput("heldStart.idleGap", 32'({busy, done}), 32'd0);
        @(negedge clk);
        checkOutput("heldStart.rerun", 32'({busy, pass, max_lat}), 32'({1'b1, 1'b0, 4'd0}));
        start = 1'b0;
        waitDone(edges);
        checkRun("heldStart.second", edges, 18, 1'b1, 4'd0, 8'h00, 4'd2);

        // Reset during WAIT of vector 3, then a clean nominal run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("midReset.vec3", 32'({busy, in1_nand, in2_nand}), 32'(3'b101));
        #2 reset_L = 1'b0;
        #1;
        checkOutput("midReset.async", 32'({busy, in_not, in1_nand, in2_nand, d_flop}), 32'd0);
        @(negedge clk);
        #2 reset_L = 1'b1;
        applyStimulus(1'b0, edges);
        checkRun("afterReset", edges, 18, 1'b1, 4'd0, 8'h00, 4'd2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
